robs_controller: RTL
====================

Name: robs_controller

Overview:
- FSM that sequences the signed Robertson's multiplier datapath for one multiply per start request.
- Drives the 15-bit control word c[14:0] and consumes the datapath status flags zr and zq.
- Sits between the lab top level (start/done handshake) and the datapath. Product is read from the datapath product bus once done pulses.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported, because zq is a divisible-by-8 test.
- ADD_POL, 1, value of c[10] that selects add on the addsub unit. Subtract is ~ADD_POL.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; returns FSM to IDLE
- start  input  1  request; sampled only in IDLE
- zr  input  1  datapath: r even (current multiplier LSB = 0)
- zq  input  1  datapath: iteration counter divisible by 8
- c  output  15  datapath control word
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, product valid

Behaviour:
- Moore FSM. c, busy and done are decoded from state only. In any state, every c bit not listed for that state is 0.
- Reset or IDLE: c=0, busy=0, done=0. Reset in any state goes to IDLE on the next edge and abandons the operation. Datapath register contents are then don't-care.
- Control bit map:
  - c0 load Y
  - c1 load counter (loads 0)
  - c2 clear A
  - c3 load X
  - c4/c5 mux_rh select: 00=A, 01=shifted, 10=alu
  - c6 mux_rl select: 0=X, 1=shifted
  - c7 mux_x select: 0=multiplier, 1=r low
  - c8 load R high
  - c9 load R low
  - c10 add/sub
  - c11 shift right (arithmetic)
  - c12 load shift register
  - c13 counter decrement
  - c14 load A
- States and outputs:
  - IDLE: start=1 -> INIT; else stay.
  - INIT: c0, c1, c2, c3 (c7=0). -> LOADR.
  - LOADR: c8, c9 (c5:4=00, c6=0); R <= {A,X}. -> DEC.
  - DEC: c13. -> TEST.
  - TEST: no controls. zr=1 -> LDSR; zr=0 -> ADD.
  - ADD: c10 = ADD_POL when zq=0, ~ADD_POL when zq=1 (last iteration subtracts). -> ADDW.
  - ADDW: c10 held at the ADD value; c8 with c5:4=10 (R high <= alu_out; the addsub unit has 1-cycle latency). -> LDSR.
  - LDSR: c12. -> SHR.
  - SHR: c11. -> WBR.
  - WBR: c8, c9, c5:4=01, c6=1; R <= shifted. zq=1 -> STORE; else -> DEC.
  - STORE: c14, c3, c7=1; A <= r high, X <= r low. -> DONE.
  - DONE: done=1, busy=1. -> IDLE.
- Iteration count: the counter is loaded to 0 and decremented once per iteration. zq is re-asserted after exactly 8 decrements (q=248).
  - zq is sampled only in TEST/ADD/ADDW/WBR, after that iteration's DEC.
  - zq=1 at INIT (q=0) is ignored.
- Latency: the start-sampling edge is cycle 0. done is high during cycle 43 + 2k, where k = number of 1 bits in the multiplier.
- start during busy is ignored; no queuing. start held high through DONE begins a new operation from IDLE on the following cycle.
- Last-iteration subtract applies only if multiplier bit 7 = 1. This is standard signed Robertson's algorithm.

Test Plan:
- Reset asserted mid-ADDW (multiplier 0x03, multiplicand 0x05) -> next cycle state IDLE, c=0, busy=0, done=0. A following start runs a clean multiply.
- 0x03 x 0x05 -> done in cycle 47, product 0x000F. ADD state visited exactly twice, both with c10=ADD_POL.
- 0xFD (-3) x 0x05 -> done in cycle 57, product 0xFFF1. Exactly one ADD has c10=~ADD_POL, and it is the 8th iteration.
- 0x80 x 0x80 (-128 x -128) -> done in cycle 45, product 0x4000. The single ADD is a subtract.
- 0x00 x 0x7F -> done in cycle 43, product 0x0000. ADD never entered. DEC asserted exactly 8 times.
- start pulsed at cycles 5 and 20 during a busy multiply -> ignored: one done pulse, busy falls 1 cycle after done. start held continuously -> back-to-back operations separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/robs_controller.sv
// Control FSM for the signed Robertson's multiplier datapath.
// Sequences one 8-bit signed multiply per start request.
module robs_controller #(
   parameter int   WIDTH   = 8,
   parameter logic ADD_POL = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_zr,
   input  logic        i_zq,
   output logic [14:0] o_c,
   output logic        o_busy,
   output logic        o_done
);

   if (WIDTH != 8) begin : g_bad_width
      $error("robs_controller: only WIDTH=8 is supported");
   end

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_LOADR,
      S_DEC,
      S_TEST,
      S_ADD,
      S_ADDW,
      S_LDSR,
      S_SHR,
      S_WBR,
      S_STORE,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_sub;
   logic   w_add;

   // last-iteration flag captured in TEST so ADD/ADDW are pure state decodes
   assign w_add = r_sub ? ~ADD_POL : ADD_POL;

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // latch zq in TEST to select subtract on the final iteration
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sub <= 1'b0;
      end else if (r_state == S_TEST) begin
         r_sub <= i_zq;
      end
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (i_start) w_next = S_INIT;
         S_INIT:  w_next = S_LOADR;
         S_LOADR: w_next = S_DEC;
         S_DEC:   w_next = S_TEST;
         S_TEST:  w_next = i_zr ? S_LDSR : S_ADD;
         S_ADD:   w_next = S_ADDW;
         S_ADDW:  w_next = S_LDSR;
         S_LDSR:  w_next = S_SHR;
         S_SHR:   w_next = S_WBR;
         S_WBR:   w_next = i_zq ? S_STORE : S_DEC;
         S_STORE: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Moore output decode: control word, busy, done
   always_comb begin
      o_c    = '0;
      o_busy = 1'b1;
      o_done = 1'b0;
      unique case (r_state)
         S_IDLE: o_busy = 1'b0;
         S_INIT: o_c[3:0] = 4'hF;
         S_LOADR: begin
            o_c[8] = 1'b1;
            o_c[9] = 1'b1;
         end
         S_DEC:  o_c[13] = 1'b1;
         S_TEST: o_c = '0;
         S_ADD:  o_c[10] = w_add;
         S_ADDW: begin
            o_c[10]  = w_add;
            o_c[8]   = 1'b1;
            o_c[5:4] = 2'b10;
         end
         S_LDSR: o_c[12] = 1'b1;
         S_SHR:  o_c[11] = 1'b1;
         S_WBR: begin
            o_c[8]   = 1'b1;
            o_c[9]   = 1'b1;
            o_c[5:4] = 2'b01;
            o_c[6]   = 1'b1;
         end
         S_STORE: begin
            o_c[14] = 1'b1;
            o_c[3]  = 1'b1;
            o_c[7]  = 1'b1;
         end
         S_DONE:  o_done = 1'b1;
         default: o_busy = 1'b0;
      endcase
   end

endmodule
